exec_mem_reg: RTL and testbench

EXEC_MEM_REG -- requirements
Module: exec_mem_reg

---
 rtl/exec_mem_reg.sv | 89 ++++++++
 tb/tb_exec_mem_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/exec_mem_reg.sv
// Execute-to-memory pipeline register plus architectural condition codes.
// M_* outputs load one cycle after their execute-stage inputs; stall holds them and bubble loads a nop.
module exec_mem_reg (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         E_icode,
  input  logic [3:0]         E_dstE,
  input  logic [3:0]         E_dstM,
  input  logic signed [63:0] E_valA,
  input  logic [1:0]         E_stat,
  input  logic               e_Cnd,
  input  logic               e_zf,
  input  logic               e_sf,
  input  logic               e_of,
  input  logic signed [63:0] e_valE,
  input  logic               M_stall,
  input  logic               M_bubble,
  input  logic [1:0]         m_stat,
  input  logic [1:0]         W_stat,
  output logic [1:0]         M_stat,
  output logic [3:0]         M_icode,
  output logic               M_Cnd,
  output logic signed [63:0] M_valE,
  output logic signed [63:0] M_valA,
  output logic [3:0]         M_dstE,
  output logic [3:0]         M_dstM,
  output logic               cc_zf,
  output logic               cc_sf,
  output logic               cc_of,
  output logic [3:0]         e_dstE
);

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] RNONE    = 4'hF;

  logic set_cc;

  // A conditional move that fails its condition must not forward a result.
  assign e_dstE = (E_icode == I_CMOV && !e_Cnd) ? RNONE : E_dstE;

  // Flags only change when no older instruction in memory/write-back is excepting.
  assign set_cc = (E_icode == I_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        M_stat  <= STAT_AOK;
        M_icode <= I_NOP;
        M_Cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= RNONE;
        M_dstM  <= RNONE;
      end else begin
        M_stat  <= E_stat;
        M_icode <= E_icode;
        M_Cnd   <= e_Cnd;
        M_valE  <= e_valE;
        M_valA  <= E_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= E_dstM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= e_zf;
      cc_sf <= e_sf;
      cc_of <= e_of;
    end
  end

endmodule

// File: tb/tb_exec_mem_reg.sv
// Directed bench for exec_mem_reg with hand-computed expected values.
module tb_exec_mem_reg;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         E_icode, E_dstE, E_dstM;
  logic signed [63:0] E_valA;
  logic [1:0]         E_stat;
  logic               e_Cnd, e_zf, e_sf, e_of;
  logic signed [63:0] e_valE;
  logic               M_stall, M_bubble;
  logic [1:0]         m_stat, W_stat;
  logic [1:0]         M_stat;
  logic [3:0]         M_icode;
  logic               M_Cnd;
  logic signed [63:0] M_valE, M_valA;
  logic [3:0]         M_dstE, M_dstM;
  logic               cc_zf, cc_sf, cc_of;
  logic [3:0]         e_dstE;

  int checks = 0;
  int failures = 0;

  exec_mem_reg dut (
    .clk(clk), .rst(rst),
    .E_icode(E_icode), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_valA(E_valA), .E_stat(E_stat),
    .e_Cnd(e_Cnd), .e_zf(e_zf), .e_sf(e_sf), .e_of(e_of), .e_valE(e_valE),
    .M_stall(M_stall), .M_bubble(M_bubble), .m_stat(m_stat), .W_stat(W_stat),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .e_dstE(e_dstE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cc(input string tag, input logic [2:0] exp);
    check(tag, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    E_icode = 4'h0; E_dstE = 4'hF; E_dstM = 4'hF; E_valA = '0; E_stat = 2'b00;
    e_Cnd = 1'b0; e_zf = 1'b0; e_sf = 1'b0; e_of = 1'b0; e_valE = '0;
    M_stall = 1'b0; M_bubble = 1'b0; m_stat = 2'b00; W_stat = 2'b00;
    #2;
    check("rst_icode", M_icode, 64'h1);
    check("rst_stat", M_stat, 64'h0);
    check("rst_dstE", M_dstE, 64'hF);
    check("rst_dstM", M_dstM, 64'hF);
    check("rst_valE", M_valE, 64'h0);
    check_cc("rst_cc", 3'b100);
    tick();
    rst = 1'b0;

    // OPq sets non-default flags, then the zero-result OPq restores zf.
    E_icode = 4'h6; E_dstE = 4'h3; e_valE = 64'sd5; e_zf = 0; e_sf = 1; e_of = 1;
    tick();
    check_cc("opq1_cc", 3'b011);
    check("opq1_valE", M_valE, 64'd5);
    e_valE = '0; e_zf = 1; e_sf = 0; e_of = 0;
    tick();
    check_cc("opq2_cc", 3'b100);
    check("opq2_icode", M_icode, 64'h6);
    check("opq2_valE", M_valE, 64'h0);

    // cmov not taken kills the destination; flags from a cmov are ignored.
    E_icode = 4'h2; e_Cnd = 0; E_dstE = 4'h3; e_valE = 64'sd77; e_zf = 0; e_sf = 1; e_of = 1;
    #1;
    check("cmov_nt_edstE", e_dstE, 64'hF);
    tick();
    check("cmov_nt_MdstE", M_dstE, 64'hF);
    check("cmov_nt_valE", M_valE, 64'd77);
    check_cc("cmov_cc_hold", 3'b100);
    e_Cnd = 1;
    #1;
    check("cmov_t_edstE", e_dstE, 64'h3);
    E_icode = 4'h7;
    #1;
    check("jxx_edstE", e_dstE, 64'h3);
    tick();
    check("jxx_Cnd", M_Cnd, 64'h1);
    check_cc("jxx_cc_hold", 3'b100);

    // Older excepting instructions block flag updates.
    E_icode = 4'h6; e_zf = 0; e_sf = 1; e_of = 0; m_stat = 2'b10;
    tick();
    check_cc("exc_mstat_cc", 3'b100);
    check("exc_mstat_icode", M_icode, 64'h6);
    m_stat = 2'b00; W_stat = 2'b11;
    tick();
    check_cc("exc_wstat_cc", 3'b100);
    W_stat = 2'b00;

    // Stall holds, flags still update under stall, bubble inserts a nop.
    E_icode = 4'h3; e_valE = 64'sh1234; E_dstE = 4'h2; E_dstM = 4'hF;
    tick();
    check("ld_valE", M_valE, 64'h1234);
    M_stall = 1; E_icode = 4'h6; e_valE = 64'shBEEF; e_zf = 0; e_sf = 0; e_of = 1;
    tick();
    check("stall1_valE", M_valE, 64'h1234);
    check_cc("stall_cc_upd", 3'b001);
    tick();
    check("stall2_valE", M_valE, 64'h1234);
    check("stall2_icode", M_icode, 64'h3);
    M_stall = 0; M_bubble = 1; E_dstM = 4'h4;
    tick();
    check("bub_icode", M_icode, 64'h1);
    check("bub_dstE", M_dstE, 64'hF);
    check("bub_dstM", M_dstM, 64'hF);
    check("bub_valE", M_valE, 64'h0);
    M_bubble = 0; E_icode = 4'h5; e_valE = 64'sh55; E_stat = 2'b01;
    tick();
    check("ld5_icode", M_icode, 64'h5);
    check("ld5_stat", M_stat, 64'h1);
    M_stall = 1; M_bubble = 1; E_icode = 4'h9; e_valE = 64'sh99;
    tick();
    check("both_icode", M_icode, 64'h5);
    check("both_valE", M_valE, 64'h55);
    M_stall = 0; M_bubble = 0;

    // Set cc=(0,1,1) with M_icode=5, then assert reset between edges.
    E_icode = 4'h6; E_stat = 2'b00; e_zf = 0; e_sf = 1; e_of = 1;
    tick();
    E_icode = 4'h5; E_stat = 2'b01;
    tick();
    check("pre_rst_icode", M_icode, 64'h5);
    check_cc("pre_rst_cc", 3'b011);
    E_icode = 4'h2; e_Cnd = 1; E_dstE = 4'h7;
    rst = 1'b1;
    #1;
    check("arst_icode", M_icode, 64'h1);
    check("arst_stat", M_stat, 64'h0);
    check_cc("arst_cc", 3'b100);
    check("arst_edstE", e_dstE, 64'h7);
    #1;
    rst = 1'b0;

    // Opaque icode and full-width passthrough.
    E_icode = 4'hC; E_stat = 2'b11; e_Cnd = 0; E_dstE = 4'h4; E_dstM = 4'h5;
    e_valE = 64'sh8000_0000_0000_0001; E_valA = 64'shFFFF_FFFF_FFFF_FFFF;
    tick();
    check("pass_valE", M_valE, 64'h8000_0000_0000_0001);
    check("pass_valA", M_valA, 64'hFFFF_FFFF_FFFF_FFFF);
    check("opaque_icode", M_icode, 64'hC);
    check("pass_stat", M_stat, 64'h3);
    check("pass_dstE", M_dstE, 64'h4);
    check("pass_dstM", M_dstM, 64'h5);
    check_cc("post_rst_cc", 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
